// File: rtl/turn_scheduler_pkg.sv
// Shared types and default timing constants for the turn scheduler and the
// countdown display.
package turn_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    COMMIT
  } sched_state_t;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } player_t;

  // 10 s turns at 50 MHz, warning for the last 3 s
  localparam int DEFAULT_TURN_CYCLES = 500000000;
  localparam int DEFAULT_WARN_CYCLES = 150000000;
  localparam int DEFAULT_CNT_W       = 29;

  function automatic logic [1:0] onehot(input player_t p);
    return (p == P1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/turn_scheduler_timer.sv
// Turn countdown: loadable down-counter that stops at zero and flags it.
module turn_timer #(
  parameter int CNT_W = 29
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load wins over counting; counting stops at zero so it never wraps
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn arbiter: grants the shared switch entry path to one player
// per turn, enforces the turn time limit and hands accepted entries to the
// game core over a valid/ready commit handshake.
module turn_scheduler
  import turn_scheduler_pkg::*;
#(
  parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES,
  parameter int WARN_CYCLES = DEFAULT_WARN_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       game_over,
  input  logic       p0_pulse,
  input  logic       p1_pulse,
  input  logic [3:0] sw_val,
  input  logic       sw_valid,
  input  logic       commit_ready,
  output logic [1:0] grant,
  output logic       commit_valid,
  output logic [3:0] commit_val,
  output logic       commit_player,
  output logic       timeout,
  output logic       foul,
  output logic       warn,
  output logic [3:0] turn_cnt
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARN_LIM = CNT_W'(WARN_CYCLES);
  localparam logic             RELOAD_WARN = (RELOAD < WARN_LIM);

  sched_state_t     state;
  player_t          active;
  player_t          other;
  player_t          first_player;
  logic [CNT_W-1:0] timer;
  logic             timer_zero;
  logic             timer_load;
  logic             timer_en;
  logic             active_press;
  logic             other_press;
  logic             accept;
  logic             commit_done;
  logic [3:0]       turn_cnt_inc;

  assign other        = player_t'(~active);
  assign active_press = (active == P0) ? p0_pulse : p1_pulse;
  assign other_press  = (active == P0) ? p1_pulse : p0_pulse;
  assign accept       = (state == TURN) && active_press && sw_valid;
  assign commit_done  = (state == COMMIT) && commit_valid && commit_ready;
  assign turn_cnt_inc = (turn_cnt == 4'd15) ? 4'd15 : turn_cnt + 4'd1;

  assign timer_load = !game_over &&
                      (((state == IDLE) && start) ||
                       ((state == TURN) && !accept && timer_zero) ||
                       commit_done);
  assign timer_en   = !game_over && (state == TURN) && !accept;

  turn_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .enable   (timer_en),
    .count    (timer),
    .zero     (timer_zero)
  );

  // Turn FSM with registered outputs; game_over overrides every state
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      active        <= P0;
      first_player  <= P0;
      grant         <= 2'b00;
      commit_valid  <= 1'b0;
      commit_val    <= 4'd0;
      commit_player <= 1'b0;
      timeout       <= 1'b0;
      foul          <= 1'b0;
      warn          <= 1'b0;
      turn_cnt      <= 4'd0;
    end else begin
      timeout <= 1'b0;
      foul    <= 1'b0;
      if (game_over) begin
        state        <= IDLE;
        grant        <= 2'b00;
        commit_valid <= 1'b0;
        warn         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            grant <= 2'b00;
            warn  <= 1'b0;
            if (start) begin
              state        <= TURN;
              active       <= first_player;
              first_player <= player_t'(~first_player);
              grant        <= onehot(first_player);
              turn_cnt     <= 4'd0;
              warn         <= RELOAD_WARN;
            end
          end
          TURN: begin
            foul <= other_press;
            if (accept) begin
              state         <= COMMIT;
              commit_valid  <= 1'b1;
              commit_val    <= sw_val;
              commit_player <= active;
              warn          <= 1'b0;
            end else if (timer_zero) begin
              timeout  <= 1'b1;
              active   <= other;
              grant    <= onehot(other);
              turn_cnt <= turn_cnt_inc;
              warn     <= RELOAD_WARN;
            end else begin
              warn <= (timer <= WARN_LIM);
            end
          end
          COMMIT: begin
            warn <= 1'b0;
            if (commit_ready) begin
              state        <= TURN;
              commit_valid <= 1'b0;
              active       <= other;
              grant        <= onehot(other);
              turn_cnt     <= turn_cnt_inc;
              warn         <= RELOAD_WARN;
            end
          end
          default: begin
            state <= IDLE;
            grant <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule
